// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Small program sequencer. A 16-entry instruction buffer is loaded while idle.
// On start, the entries 0..len-1 are issued one at a time to a control unit.
//
// Each instruction is presented for exactly one cycle with w=1. The fields
// then stay stable until control pulses done. After the last instruction
// completes, finished pulses for one cycle and the block returns to idle.
//
// Instruction word layout: {func[2:0], rx[3:0], ry[3:0], data[3:0]}.
//
// Ports
//   clk        in   clock; all state changes on its rising edge
//   rst        in   synchronous active-high reset
//   prog_we    in   buffer write strobe (honoured only while idle)
//   prog_addr  in   buffer write address
//   prog_data  in   instruction word to write
//   prog_len   in   number of instructions to run (0..16, larger means 16)
//   start      in   begin execution at entry 0 (honoured only while idle)
//   done       in   control has completed the current instruction
//   w          out  one-cycle instruction-valid strobe
//   func       out  opcode field of the current instruction
//   rx         out  destination register select
//   ry         out  source register select
//   data       out  immediate field
//   pc         out  index of the current or next instruction
//   busy       out  high while a program is running
//   finished   out  one-cycle pulse after the last instruction completes
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int DEPTH = 16,
    parameter int IW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [3:0]    prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic [4:0]    prog_len,
    input  logic          start,
    input  logic          done,
    output logic          w,
    output logic [2:0]    func,
    output logic [3:0]    rx,
    output logic [3:0]    ry,
    output logic [3:0]    data,
    output logic [3:0]    pc,
    output logic          busy,
    output logic          finished
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   buf_q [DEPTH];
    logic [IW-1:0]   instr_q;
    logic [3:0]      pc_q;
    logic [4:0]      len_q;
    logic            w_q;
    logic            busy_q;
    logic            finished_q;

    // pc+1 is computed in 5 bits so that a 16-entry run compares 16 == 16
    // instead of wrapping back to 0.
    logic [4:0]      pc_inc;
    assign pc_inc = {1'b0, pc_q} + 5'd1;

    // Program buffer has no reset, so its contents survive rst.
    // Writes are accepted only while idle and not in reset.
    always_ff @(posedge clk) begin
        if (!rst && prog_we && (state_q == S_IDLE)) begin
            buf_q[prog_addr] <= prog_data;
        end
    end

    // The sequencer registers every output directly on each transition.
    // The instruction register is loaded from the buffer on the edge that
    // enters ISSUE. This is the buffer's registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            pc_q       <= 4'd0;
            len_q      <= 5'd0;
            w_q        <= 1'b0;
            busy_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            w_q        <= 1'b0;
            finished_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (prog_len != 5'd0) begin
                            len_q   <= (prog_len > 5'd16) ? 5'd16 : prog_len;
                            pc_q    <= 4'd0;
                            instr_q <= buf_q[4'd0];
                            w_q     <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= S_ISSUE;
                        end else begin
                            finished_q <= 1'b1;
                            state_q    <= S_FIN;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        if (pc_inc == len_q) begin
                            finished_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_FIN;
                        end else begin
                            pc_q    <= pc_inc[3:0];
                            instr_q <= buf_q[pc_inc[3:0]];
                            w_q     <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w        = w_q;
    assign func     = instr_q[14:12];
    assign rx       = instr_q[11:8];
    assign ry       = instr_q[7:4];
    assign data     = instr_q[3:0];
    assign pc       = pc_q;
    assign busy     = busy_q;
    assign finished = finished_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Randomized self-checking bench for instr_fetch. The reference model has two
// parts: a shadow copy of the program buffer, and the rule that a run of
// length L issues entries 0..L-1 in order and then raises one finished pulse.
// Outputs are sampled 1 time unit after each rising edge, and inputs are
// driven at the same point.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [14:0] prog_data;
    logic [4:0]  prog_len;
    logic        start;
    logic        done;
    logic        w;
    logic [2:0]  func;
    logic [3:0]  rx;
    logic [3:0]  ry;
    logic [3:0]  data;
    logic [3:0]  pc;
    logic        busy;
    logic        finished;

    logic [14:0] mem_m [16];
    int          n_checks = 0;
    int          n_pass   = 0;

    instr_fetch #(.DEPTH(16), .IW(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_len  (prog_len),
        .start     (start),
        .done      (done),
        .w         (w),
        .func      (func),
        .rx        (rx),
        .ry        (ry),
        .data      (data),
        .pc        (pc),
        .busy      (busy),
        .finished  (finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        start   = 1'b0;
        done    = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [14:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
        mem_m[a]  = d;
        $display("load addr=%0d data=%04h", a, d);
    endtask

    task automatic check_fields(input string tag, input logic [14:0] e);
        chk({tag, "_func"}, 32'(func), 32'(e[14:12]));
        chk({tag, "_rx"},   32'(rx),   32'(e[11:8]));
        chk({tag, "_ry"},   32'(ry),   32'(e[7:4]));
        chk({tag, "_data"}, 32'(data), 32'(e[3:0]));
    endtask

    // Drive junk that the DUT is expected to ignore. The shadow buffer is
    // deliberately left unchanged.
    task automatic distract();
        start     = 1'b1;
        prog_len  = 5'($urandom_range(31, 1));
        prog_we   = 1'b1;
        prog_addr = 4'($urandom);
        prog_data = 15'($urandom);
    endtask

    // One full program run. The done delay in WAIT is drawn from [dmin,dmax].
    // With dis=1, done is pulsed in ISSUE, and start/prog_we are pulsed in
    // WAIT and FIN.
    task automatic run_prog(input int len_in, input int dmin, input int dmax, input bit dis);
        int          l;
        int          d;
        logic [14:0] e;
        l = (len_in > 16) ? 16 : len_in;
        prog_len = 5'(len_in);
        start    = 1'b1;
        step();
        start    = 1'b0;
        if (l == 0) begin
            chk("len0_w",    32'(w),        32'd0);
            chk("len0_fin",  32'(finished), 32'd1);
            chk("len0_busy", 32'(busy),     32'd0);
            step();
            chk("len0_fin_drop", 32'(finished), 32'd0);
            chk("len0_busy2",    32'(busy),     32'd0);
            chk("len0_w2",       32'(w),        32'd0);
            $display("run len=%0d: no issue, finished pulse", len_in);
            return;
        end
        for (int i = 0; i < l; i++) begin
            e = mem_m[i];
            chk("issue_w",    32'(w),        32'd1);
            chk("issue_pc",   32'(pc),       32'(i));
            chk("issue_busy", 32'(busy),     32'd1);
            chk("issue_fin",  32'(finished), 32'd0);
            check_fields("issue", e);
            if (dis) done = 1'b1;
            step();
            done = 1'b0;
            d = int'($urandom_range(dmax, dmin));
            for (int k = 0; k <= d; k++) begin
                chk("wait_w",    32'(w),    32'd0);
                chk("wait_busy", 32'(busy), 32'd1);
                chk("wait_pc",   32'(pc),   32'(i));
                check_fields("wait", e);
                if (k == d) done = 1'b1;
                else if (dis) distract();
                step();
                clear_inputs();
            end
        end
        chk("fin_pulse", 32'(finished), 32'd1);
        chk("fin_busy",  32'(busy),     32'd0);
        chk("fin_w",     32'(w),        32'd0);
        chk("fin_pc",    32'(pc),       32'(l - 1));
        if (dis) distract();
        step();
        clear_inputs();
        chk("idle_fin",  32'(finished), 32'd0);
        chk("idle_busy", 32'(busy),     32'd0);
        chk("idle_w",    32'(w),        32'd0);
        chk("idle_pc",   32'(pc),       32'(l - 1));
        step();
        chk("no_extra_issue", 32'(w), 32'd0);
        $display("run len=%0d issued=%0d dist=%0d", len_in, l, dis);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_w"},    32'(w),        32'd0);
        chk({tag, "_func"}, 32'(func),     32'd0);
        chk({tag, "_rx"},   32'(rx),       32'd0);
        chk({tag, "_ry"},   32'(ry),       32'd0);
        chk({tag, "_data"}, 32'(data),     32'd0);
        chk({tag, "_pc"},   32'(pc),       32'd0);
        chk({tag, "_busy"}, 32'(busy),     32'd0);
        chk({tag, "_fin"},  32'(finished), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 4'd0;
        prog_data = 15'd0;
        prog_len  = 5'd0;
        start     = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = 15'd0;

        step();
        step();
        check_all_zero("reset");
        $display("reset applied");
        rst = 1'b0;
        step();

        // Three-instruction program, done pulsed 3 cycles after each w.
        load(4'd0, {3'b000, 4'd0, 4'd1, 4'b0001});
        load(4'd1, {3'b000, 4'd1, 4'd0, 4'b1000});
        load(4'd2, {3'b010, 4'd0, 4'd1, 4'b1010});
        run_prog(3, 2, 2, 1'b0);

        // Zero-length program.
        run_prog(0, 0, 0, 1'b0);

        // Full buffer, back-to-back done: issues spaced by 2 cycles.
        for (int i = 0; i < 16; i++) load(4'(i), 15'($urandom));
        run_prog(16, 0, 0, 1'b0);

        // Over-range length is treated as 16.
        run_prog(20, 0, 2, 1'b0);

        // Ignored done, start and prog_we, followed by a full replay to
        // confirm the buffer is intact.
        run_prog(5, 1, 3, 1'b1);
        run_prog(16, 0, 1, 1'b0);

        // Random programs.
        for (int t = 0; t < 8; t++) begin
            for (int j = 0; j < 4; j++) load(4'($urandom), 15'($urandom));
            run_prog(int'($urandom_range(20, 0)), 0, 3, 1'($urandom));
        end

        // Reset during WAIT of instruction 1, with start, done and prog_we
        // also asserted on that edge.
        prog_len = 5'd4;
        start    = 1'b1;
        step();
        start    = 1'b0;
        step();
        done     = 1'b1;
        step();
        done     = 1'b0;
        chk("pre_rst_pc", 32'(pc), 32'd1);
        chk("pre_rst_w",  32'(w),  32'd1);
        step();
        rst       = 1'b1;
        start     = 1'b1;
        done      = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = ~mem_m[0];
        step();
        clear_inputs();
        check_all_zero("midrst");
        $display("reset during WAIT of instruction 1");
        rst = 1'b0;
        step();
        chk("post_rst_fin",  32'(finished), 32'd0);
        chk("post_rst_busy", 32'(busy),     32'd0);
        chk("post_rst_w",    32'(w),        32'd0);
        run_prog(4, 0, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
